wdg_timer: RTL

Windowed watchdog timer core with a small memory-mapped register interface. It is serviced by the RISC-V core through a key-protected kick register. When the core fails to service it correctly, it raises wdg_to. wdg_to drives the downstream reset controller, which resets the core and then this block.

---
 rtl/wdg_timer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/wdg_timer.sv
// Windowed watchdog timer with key-protected kick and small register file.
// Optional pre-warning interrupt is built when WDG_PREWARN_EN is defined.
module wdg_timer #(
  parameter int                    CNT_WIDTH       = 32,
  parameter int                    PRESCALE_WIDTH  = 16,
  parameter logic [CNT_WIDTH-1:0]  DEFAULT_TIMEOUT = 32'h0000_FFFF,
  parameter logic [31:0]           KICK_KEY        = 32'hA5C3_5A3C
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        wdg_to,
  output logic        irq
);

  typedef enum logic [1:0] {S_DISABLED, S_RUNNING, S_EXPIRED} state_t;

  state_t                    r_state;
  logic                      r_en;
  logic                      r_lock;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic [CNT_WIDTH-1:0]      r_timeout;
  logic [CNT_WIDTH-1:0]      r_window;
  logic [CNT_WIDTH-1:0]      r_cnt;
  logic [PRESCALE_WIDTH-1:0] r_pcnt;
  logic [31:0]               r_rdata;
  logic                      r_wdg_to;

  logic w_wr_ctrl;
  logic w_wr_pre;
  logic w_wr_timeout;
  logic w_wr_window;
  logic w_wr_kick;
  logic w_tick;
  logic w_kick_ok;
  logic w_timeout_hit;
  logic w_status_pw;

  // Configuration writes are blocked once LOCK is set; only res_n clears it.
  assign w_wr_ctrl     = wr_en && (addr == 3'd0) && !r_lock;
  assign w_wr_pre      = wr_en && (addr == 3'd1) && !r_lock;
  assign w_wr_timeout  = wr_en && (addr == 3'd2) && !r_lock;
  assign w_wr_window   = wr_en && (addr == 3'd3) && !r_lock;
  assign w_wr_kick     = wr_en && (addr == 3'd4);

  assign w_tick        = (r_state == S_RUNNING) && (r_pcnt == r_prescale);
  assign w_kick_ok     = (wdata == KICK_KEY) && (r_cnt >= r_window);
  // >= rather than == so a TIMEOUT lowered below cnt still expires.
  assign w_timeout_hit = w_tick && (r_cnt >= r_timeout);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_en       <= 1'b0;
      r_lock     <= 1'b0;
      r_prescale <= '0;
      r_timeout  <= DEFAULT_TIMEOUT;
      r_window   <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_en   <= wdata[0];
        r_lock <= wdata[1];
      end
      if (w_wr_pre)     r_prescale <= wdata[PRESCALE_WIDTH-1:0];
      if (w_wr_timeout) r_timeout  <= wdata[CNT_WIDTH-1:0];
      if (w_wr_window)  r_window   <= wdata[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state  <= S_DISABLED;
      r_cnt    <= '0;
      r_pcnt   <= '0;
      r_wdg_to <= 1'b0;
    end else begin
      case (r_state)
        S_DISABLED: begin
          r_cnt  <= '0;
          r_pcnt <= '0;
          if (w_wr_ctrl && wdata[0]) r_state <= S_RUNNING;
        end
        S_RUNNING: begin
          // A valid kick outranks an expiring tick in the same cycle.
          if (w_wr_kick) begin
            if (w_kick_ok) begin
              r_cnt  <= '0;
              r_pcnt <= '0;
            end else begin
              r_state  <= S_EXPIRED;
              r_wdg_to <= 1'b1;
            end
          end else if (w_timeout_hit) begin
            r_state  <= S_EXPIRED;
            r_wdg_to <= 1'b1;
          end else if (w_wr_ctrl && !wdata[0]) begin
            r_state <= S_DISABLED;
            r_cnt   <= '0;
            r_pcnt  <= '0;
          end else if (w_tick) begin
            r_cnt  <= r_cnt + CNT_WIDTH'(1);
            r_pcnt <= '0;
          end else begin
            r_pcnt <= r_pcnt + PRESCALE_WIDTH'(1);
          end
        end
        S_EXPIRED: begin
          r_wdg_to <= 1'b1;
        end
        default: r_state <= S_DISABLED;
      endcase
    end
  end

`ifdef WDG_PREWARN_EN
  logic r_prewarn;
  logic w_wr_status;
  logic w_pw_set;
  logic w_pw_clr;

  assign w_wr_status = wr_en && (addr == 3'd6);
  assign w_pw_set    = w_tick && (r_cnt == (r_timeout >> 1));
  assign w_pw_clr    = (w_wr_kick && (r_state == S_RUNNING) && w_kick_ok) ||
                       (w_wr_status && wdata[1]);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_prewarn <= 1'b0;
    end else if (w_pw_set) begin
      r_prewarn <= 1'b1;
    end else if (w_pw_clr) begin
      r_prewarn <= 1'b0;
    end
  end

  assign w_status_pw = r_prewarn;
  assign irq         = r_prewarn;
`else
  assign w_status_pw = 1'b0;
  assign irq         = 1'b0;
`endif

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_rdata <= '0;
    end else if (rd_en) begin
      case (addr)
        3'd0:    r_rdata <= {30'b0, r_lock, r_en};
        3'd1:    r_rdata <= 32'(r_prescale);
        3'd2:    r_rdata <= 32'(r_timeout);
        3'd3:    r_rdata <= 32'(r_window);
        3'd5:    r_rdata <= 32'(r_cnt);
        3'd6:    r_rdata <= {30'b0, w_status_pw, r_wdg_to};
        default: r_rdata <= '0;
      endcase
    end
  end

  assign rdata  = r_rdata;
  assign wdg_to = r_wdg_to;

endmodule
